// File: rtl/ctr_pkg.sv
// Shared definitions for the counter step monitor: event codes, FSM states, event width.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ctr_pkg;

  // Event type carried in the top two bits of every queued event
  typedef enum logic [1:0] {
    EVT_NONE     = 2'b00,
    EVT_WRAP     = 2'b01,
    EVT_STEP_ERR = 2'b10,
    EVT_HOLD     = 2'b11
  } evt_type_e;

  // Monitor arming state; UNARMED has no valid previous sample to compare against
  typedef enum logic {
    ST_UNARMED  = 1'b0,
    ST_TRACKING = 1'b1
  } state_e;

  // Width of an event word: {type[1:0], count value}
  function automatic int evt_w(input int cnt_w);
    return cnt_w + 2;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through event queue with occupancy counter.
// Latency: a push is visible at head one cycle later; pop takes effect at the clock edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module evt_fifo #(
  parameter int DW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Pointer/occupancy update; a full queue still accepts a push when it also pops
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    head     = empty ? '0 : mem_q[rd_ptr_q];
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset empties the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while empty because head is gated to zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ctr_step_monitor.sv
// Watches an upstream counter and queues WRAP / STEP_ERR (and HOLD with CTR_HOLD_ERR_EN) events.
// Latency: an event appears on evt_valid/evt_data the cycle after the offending sample.
// Backpressure: evt_ready stalls the queue; events arriving while full are dropped and flagged.
module ctr_step_monitor
  import ctr_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          cnt_in,
  input  logic                      cnt_vld,
  output logic [evt_w(CNT_W)-1:0]   evt_data,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [7:0]                wrap_cnt,
  output logic                      err_sticky,
  output logic                      ovf_sticky
);

  localparam int EW = evt_w(CNT_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_inc;
  evt_type_e        evt_type;
  logic             fifo_push;
  logic             fifo_pop;
  logic [EW-1:0]    fifo_head;
  logic             fifo_empty;
  logic             fifo_full;

  // Classify each sample against the previous one and derive next state and flags
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    evt_type   = EVT_NONE;
    cnt_inc    = prev_q + 1'b1;
    if (cnt_vld) begin
      prev_d  = cnt_in;
      state_d = ST_TRACKING;
      if (state_q == ST_TRACKING) begin
        if (cnt_in == cnt_inc) begin
          // A normal +1 step only becomes an event when it is the roll-over to zero
          if (prev_q == '1) begin
            evt_type = EVT_WRAP;
          end
        end else if (cnt_in == prev_q) begin
`ifdef CTR_HOLD_ERR_EN
          evt_type = EVT_HOLD;
`else
          evt_type = EVT_NONE;
`endif
        end else begin
          evt_type = EVT_STEP_ERR;
        end
      end
    end

    if ((evt_type == EVT_WRAP) && (wrap_cnt_q != 8'hFF)) begin
      wrap_cnt_d = wrap_cnt_q + 8'd1;
    end
    // Error flag is raised even if the event itself is later dropped
    if ((evt_type == EVT_STEP_ERR) || (evt_type == EVT_HOLD)) begin
      err_d = 1'b1;
    end

    fifo_pop  = !fifo_empty && evt_ready;
    fifo_push = (evt_type != EVT_NONE);
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  // State, previous sample and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_UNARMED;
      prev_q     <= '0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  evt_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({evt_type, cnt_in}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign evt_data   = fifo_head;
  assign evt_valid  = !fifo_empty;
  assign wrap_cnt   = wrap_cnt_q;
  assign err_sticky = err_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ctr_step_monitor.sv
// Directed bench for ctr_step_monitor: wrap, step error, hold, overflow, reset, saturation.
// Latency: expects events one cycle after the offending sample.
// Backpressure: drives evt_ready low to fill the queue, high to drain it.
module tb_ctr_step_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_in;
  logic       cnt_vld;
  logic [5:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] wrap_cnt;
  logic       err_sticky;
  logic       ovf_sticky;

  int checks = 0;
  int errors = 0;
  logic [5:0] got[$];

  ctr_step_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_vld    (cnt_vld),
    .evt_data   (evt_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .wrap_cnt   (wrap_cnt),
    .err_sticky (err_sticky),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  // Record every accepted event in order
  always @(posedge clk) begin
    if (!rst && evt_valid && evt_ready) got.push_back(evt_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [3:0] v);
    cnt_vld = 1'b1;
    cnt_in  = v;
    @(posedge clk);
    #1;
    cnt_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    cnt_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    cnt_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
  endtask

  initial begin
    rst       = 1'b1;
    cnt_vld   = 1'b1;
    cnt_in    = 4'd7;
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_wrap", 32'(wrap_cnt), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    check("rst_ovf", 32'(ovf_sticky), 32'd0);
    rst     = 1'b0;
    cnt_vld = 1'b0;
    got.delete();

    // Normal wrap: 0..15 then 0
    for (int v = 0; v < 16; v++) sample(4'(v));
    sample(4'd0);
    idle(2);
    check("wrap_nevt", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("wrap_evt", 32'(got[0]), 32'b01_0000);
    check("wrap_cnt", 32'(wrap_cnt), 32'd1);
    check("wrap_err", 32'(err_sticky), 32'd0);

    // Step error: 3, 4, 7 then 8
    do_reset();
    sample(4'd3); sample(4'd4); sample(4'd7);
    idle(2);
    check("step_nevt", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("step_evt", 32'(got[0]), 32'b10_0111);
    check("step_err", 32'(err_sticky), 32'd1);
    sample(4'd8);
    idle(2);
    check("step_after", 32'(got.size()), 32'd1);

    // Hold: 5, 5
    do_reset();
    sample(4'd5); sample(4'd5);
    idle(2);
`ifdef CTR_HOLD_ERR_EN
    check("hold_nevt", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("hold_evt", 32'(got[0]), 32'b11_0101);
    check("hold_err", 32'(err_sticky), 32'd1);
`else
    check("hold_nevt", 32'(got.size()), 32'd0);
    check("hold_err", 32'(err_sticky), 32'd0);
`endif

    // Overflow: 5 step errors into a 4-deep queue
    do_reset();
    evt_ready = 1'b0;
    sample(4'd0); sample(4'd2); sample(4'd4); sample(4'd6);
    sample(4'd8);
    check("full_noovf", 32'(ovf_sticky), 32'd0);
    sample(4'd10);
    check("ovf_flag", 32'(ovf_sticky), 32'd1);
    check("ovf_valid", 32'(evt_valid), 32'd1);
    check("ovf_head", 32'(evt_data), 32'b10_0010);
    idle(3);
    check("ovf_stable", 32'(evt_data), 32'b10_0010);
    evt_ready = 1'b1;
    idle(6);
    check("ovf_ndrain", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      check("drain0", 32'(got[0]), 32'b10_0010);
      check("drain1", 32'(got[1]), 32'b10_0100);
      check("drain2", 32'(got[2]), 32'b10_0110);
      check("drain3", 32'(got[3]), 32'b10_1000);
    end
    check("drain_empty", 32'(evt_valid), 32'd0);

    // Full queue with push and pop in the same cycle
    do_reset();
    evt_ready = 1'b0;
    sample(4'd0); sample(4'd2); sample(4'd4); sample(4'd6); sample(4'd8);
    evt_ready = 1'b1;
    sample(4'd10);
    evt_ready = 1'b0;
    check("pp_noovf", 32'(ovf_sticky), 32'd0);
    check("pp_head", 32'(evt_data), 32'b10_0100);
    evt_ready = 1'b1;
    idle(6);
    check("pp_ndrain", 32'(got.size()), 32'd5);
    if (got.size() == 5) check("pp_last", 32'(got[4]), 32'b10_1010);

    // Reset mid-operation with two events queued
    do_reset();
    evt_ready = 1'b0;
    sample(4'd14); sample(4'd15); sample(4'd0); sample(4'd9);
    check("mid_valid", 32'(evt_valid), 32'd1);
    check("mid_wrap", 32'(wrap_cnt), 32'd1);
    check("mid_err", 32'(err_sticky), 32'd1);
    rst       = 1'b1;
    cnt_vld   = 1'b1;
    cnt_in    = 4'd3;
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    cnt_vld = 1'b0;
    got.delete();
    check("mrst_valid", 32'(evt_valid), 32'd0);
    check("mrst_data", 32'(evt_data), 32'd0);
    check("mrst_wrap", 32'(wrap_cnt), 32'd0);
    check("mrst_err", 32'(err_sticky), 32'd0);
    check("mrst_ovf", 32'(ovf_sticky), 32'd0);
    sample(4'd9);
    idle(2);
    check("mrst_first", 32'(got.size()), 32'd0);
    check("mrst_err2", 32'(err_sticky), 32'd0);
    sample(4'd10); sample(4'd12);
    idle(2);
    check("mrst_rearm", 32'(got.size()), 32'd1);

    // Saturation: 300 wraps
    do_reset();
    evt_ready = 1'b1;
    sample(4'd15);
    for (int k = 0; k < 300; k++) begin
      for (int v = 0; v < 16; v++) sample(4'(v));
      if (k == 253) check("sat_254", 32'(wrap_cnt), 32'd254);
    end
    idle(2);
    check("sat_cnt", 32'(wrap_cnt), 32'd255);
    check("sat_err", 32'(err_sticky), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
